// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter FSM encoding
// and the parity helper used on both sides of the link.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam int MAX_DATA_W = 9;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Returns the parity bit a correct frame carries; narrower words are
  // zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data,
                                       input logic [1:0]            mode);
    case (mode)
      PARITY_EVEN: return ^data;
      PARITY_ODD:  return ~(^data);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: ticks after half a bit period in half mode (start-bit
// centring) and after a full period otherwise; restarts on every tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_half,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_half ? HALF_LAST : FULL_LAST;
  assign o_tick = !i_clr && (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with mid-bit sampling, valid/ready output,
// per-frame parity/framing flags and an overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [1:0] MODE      = 2'(PARITY_MODE);

  logic              r_sync1;
  logic              r_sync2;
  uart_state_t       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_bit_cnt;
  logic              r_par_err;
  logic              r_frm_err;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;

  logic w_rxs;
  logic w_tick;
  logic w_clr;
  logic w_half;

  assign w_rxs  = r_sync2;
  assign w_clr  = (r_state == ST_IDLE);
  assign w_half = (r_state == ST_START);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_half (w_half),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_ovr   <= 1'b0;

      // An accept drops valid unless DONE below reloads it in the same cycle.
      if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_state   <= ST_START;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= w_rxs ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= {w_rxs, r_shift[DATA_W-1:1]};
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_par_err <= parity_calc(MAX_DATA_W'(r_shift), MODE) ^ w_rxs;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (!w_rxs) begin
              r_frm_err <= 1'b1;
            end
            if (r_bit_cnt == LAST_STOP) begin
              r_state <= ST_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if (!r_valid || rx_ready) begin
            r_data  <= r_shift;
            r_perr  <= r_par_err;
            r_ferr  <= r_frm_err;
            r_valid <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != ST_IDLE);

endmodule
